int_to_modq: RTL and testbench

INT_TO_MODQ -- requirements
Module: int_to_modq

---
 rtl/int_to_modq.sv | 194 +++++++++++++++++++
 tb/tb_int_to_modq.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_to_modq.sv
// -----------------------------------------------------------------------------
// int_to_modq
//
// Purpose:
//   Reduces a signed two's-complement integer to its mathematical residue
//   modulo an odd constant Q. The result is always in [0, Q-1]. Inputs
//   outside the signed IN_BITS range return 0 with an error flag. A saturating
//   counter keeps track of how many flagged samples were delivered.
//
//   Pipeline (one common enable, latency 3, throughput 1 sample per clk):
//     input register    : captures the accepted sample
//     stage 1           : range check and sign split  -> r_s1_*
//     stage 2           : Barrett reduction of |x|    -> r_s2_*
//     stage 3           : sign correction             -> r_out_* (outputs)
//
// Parameters:
//   Q        modulus; must be odd with 2 <= Q < 2^16
//   IN_BITS  legal signed input width, 2..48
//
// Ports:
//   clk            in   sole clock, rising edge
//   rst            in   asynchronous active-high reset
//   a_tvalid       in   input sample valid
//   a_tdata[63:0]  in   signed input sample
//   a_tready       out  block accepts a sample this cycle
//   result_tready  in   downstream accepts the output sample
//   result_tvalid  out  output sample valid
//   result_tdata   out  residue in [0, Q-1], zero-extended to 16 bits
//   result_tuser   out  range-error flag for this sample
//   err_count      out  saturating count of delivered range-error samples
// -----------------------------------------------------------------------------
module int_to_modq #(
  parameter int Q       = 12289,
  parameter int IN_BITS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_tvalid,
  input  logic [63:0] a_tdata,
  output logic        a_tready,
  input  logic        result_tready,
  output logic        result_tvalid,
  output logic [15:0] result_tdata,
  output logic        result_tuser,
  output logic [15:0] err_count
);

  // The magnitude of the most negative legal input is 2^(IN_BITS-1), which
  // still fits in IN_BITS unsigned bits.
  localparam int MAG_W = IN_BITS;

  // Reduction arithmetic width: wide enough for the magnitude plus a
  // remainder below 2Q (17 bits for Q < 2^16).
  localparam int CW = IN_BITS + 17;

  // Barrett constant m = floor(2^IN_BITS / Q). Because |x| < 2^IN_BITS the
  // quotient estimate floor(|x| * m / 2^IN_BITS) undershoots by at most one,
  // so the remainder lands in [0, 2Q) and one conditional subtract finishes.
  localparam logic [CW-1:0] BARRETT_M = CW'((64'd1 << IN_BITS) / 64'(Q));
  localparam logic [CW-1:0] Q_CW      = CW'(Q);
  localparam logic [15:0]   Q_16      = 16'(Q);

  // ---------------------------------------------------------------------------
  // Handshake: every stage moves together. The pipeline can only stall when
  // the output register holds a sample that downstream is not taking.
  // ---------------------------------------------------------------------------
  logic w_en;

  logic        r_in_valid;
  logic [63:0] r_in_data;

  logic             r_s1_valid;
  logic             r_s1_neg;
  logic             r_s1_err;
  logic [MAG_W-1:0] r_s1_mag;

  logic        r_s2_valid;
  logic        r_s2_neg;
  logic        r_s2_err;
  logic [15:0] r_s2_rem;

  logic        r_out_valid;
  logic [15:0] r_out_data;
  logic        r_out_user;
  logic [15:0] r_err_count;

  assign w_en     = !r_out_valid || result_tready;
  assign a_tready = w_en;

  // ---------------------------------------------------------------------------
  // Stage 1 logic: range check and sign split on the captured input.
  // In range means every bit from IN_BITS-1 upward equals the sign bit, i.e.
  // the arithmetic shift leaves either all zeros or all ones.
  // ---------------------------------------------------------------------------
  logic signed [63:0] w_hi;
  logic               w_in_range;
  logic               w_neg;
  logic [MAG_W-1:0]   w_mag;

  assign w_hi       = $signed(r_in_data) >>> (IN_BITS - 1);
  assign w_in_range = (w_hi == '0) || (w_hi == '1);
  assign w_neg      = r_in_data[63];
  assign w_mag      = MAG_W'(w_neg ? (64'd0 - r_in_data) : r_in_data);

  // ---------------------------------------------------------------------------
  // Stage 2 logic: Barrett reduction of the magnitude.
  // qhat * Q never exceeds |x|, so the CW-bit difference cannot wrap.
  // ---------------------------------------------------------------------------
  logic [2*CW-1:0] w_prod;
  logic [CW-1:0]   w_qhat;
  logic [CW-1:0]   w_r;
  logic [15:0]     w_rem;

  assign w_prod = (2*CW)'(r_s1_mag) * (2*CW)'(BARRETT_M);
  assign w_qhat = CW'(w_prod >> IN_BITS);
  assign w_r    = CW'(r_s1_mag) - (w_qhat * Q_CW);
  assign w_rem  = 16'((w_r >= Q_CW) ? (w_r - Q_CW) : w_r);

  // ---------------------------------------------------------------------------
  // Stage 3 logic: fold negative values back into [0, Q-1]. A zero remainder
  // stays zero so -kQ maps to 0 rather than Q. Error samples force 0.
  // ---------------------------------------------------------------------------
  logic [15:0] w_out_data;

  assign w_out_data = r_s2_err                        ? 16'd0 :
                      (r_s2_neg && (r_s2_rem != '0)) ? (Q_16 - r_s2_rem) :
                                                       r_s2_rem;

  // ---------------------------------------------------------------------------
  // Pipeline registers. Valid bits copy their predecessor on every enabled
  // edge, which also clears a stage when a bubble moves into it.
  // NOTE: sequential state uses non-blocking assignments so all stages sample
  // their predecessors' pre-edge values; blocking would collapse the pipeline.
  // NOTE: the data registers are reset as well; they are few and narrow, and
  // it keeps result_tdata/result_tuser at 0 during reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_valid  <= 1'b0;
      r_in_data   <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_neg    <= 1'b0;
      r_s1_err    <= 1'b0;
      r_s1_mag    <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_neg    <= 1'b0;
      r_s2_err    <= 1'b0;
      r_s2_rem    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_user  <= 1'b0;
    end else if (w_en) begin
      // Data is only captured with a valid sample so idle bus values never
      // enter the pipeline.
      r_in_valid <= a_tvalid;
      if (a_tvalid) begin
        r_in_data <= a_tdata;
      end

      r_s1_valid <= r_in_valid;
      r_s1_neg   <= w_neg;
      r_s1_err   <= !w_in_range;
      r_s1_mag   <= w_in_range ? w_mag : '0;

      r_s2_valid <= r_s1_valid;
      r_s2_neg   <= r_s1_neg;
      r_s2_err   <= r_s1_err;
      r_s2_rem   <= w_rem;

      r_out_valid <= r_s2_valid;
      r_out_data  <= w_out_data;
      r_out_user  <= r_s2_err;
    end
  end

  // ---------------------------------------------------------------------------
  // Error counter: counts on the output handshake itself, so a sample held
  // under backpressure is counted exactly once, when it finally leaves.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (r_out_valid && result_tready && r_out_user &&
                 (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign result_tvalid = r_out_valid;
  assign result_tdata  = r_out_data;
  assign result_tuser  = r_out_user;
  assign err_count     = r_err_count;

endmodule

// File: tb/tb_int_to_modq.sv
// -----------------------------------------------------------------------------
// tb_int_to_modq
//
// Self-checking bench for int_to_modq (Q = 12289, IN_BITS = 32).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Expected results are pushed to a queue when a sample is
// accepted and compared by the output monitor when a sample is delivered.
// -----------------------------------------------------------------------------
module tb_int_to_modq;

  localparam int    Q_P     = 12289;
  localparam longint Q_L    = 64'sd12289;
  localparam int    IN_BITS = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_tvalid;
  logic [63:0] a_tdata;
  logic        a_tready;
  logic        result_tready;
  logic        result_tvalid;
  logic [15:0] result_tdata;
  logic        result_tuser;
  logic [15:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  // {tuser, tdata} of every accepted sample, oldest first
  logic [16:0] exp_q[$];

  int_to_modq #(
    .Q       (Q_P),
    .IN_BITS (IN_BITS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .a_tvalid      (a_tvalid),
    .a_tdata       (a_tdata),
    .a_tready      (a_tready),
    .result_tready (result_tready),
    .result_tvalid (result_tvalid),
    .result_tdata  (result_tdata),
    .result_tuser  (result_tuser),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  // Reference: plain signed remainder, shifted into [0, Q-1].
  function automatic logic [16:0] model(input longint x);
    longint r;
    if (x > 64'sd2147483647 || x < -64'sd2147483648) begin
      return {1'b1, 16'd0};
    end
    r = x % Q_L;
    if (r < 0) r = r + Q_L;
    return {1'b0, 16'(r)};
  endfunction

  // ---------------------------------------------------------------------------
  // Output monitor: scoreboard compare, stall stability, a_tready relation.
  // ---------------------------------------------------------------------------
  logic        mon_stall = 1'b0;
  logic [15:0] mon_data  = '0;
  logic        mon_user  = 1'b0;
  logic [16:0] mon_exp;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      n_checks++;
      if (a_tready !== !(result_tvalid && !result_tready)) begin
        n_fail++;
        $display("FAIL a_tready_rule: a_tready=%b required %b (tvalid=%b tready=%b)",
                 a_tready, !(result_tvalid && !result_tready), result_tvalid, result_tready);
      end
      if (mon_stall) begin
        n_checks++;
        if (result_tvalid !== 1'b1 || result_tdata !== mon_data || result_tuser !== mon_user) begin
          n_fail++;
          $display("FAIL stall_hold: got valid=%b data=%0d user=%b, required valid=1 data=%0d user=%b",
                   result_tvalid, result_tdata, result_tuser, mon_data, mon_user);
        end
      end
      if (result_tvalid === 1'b1 && result_tready === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL out_unexpected: got data=%0d user=%b, required no output",
                   result_tdata, result_tuser);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({result_tuser, result_tdata} !== mon_exp) begin
            n_fail++;
            $display("FAIL out_value: got data=%0d user=%b, required data=%0d user=%b",
                     result_tdata, result_tuser, mon_exp[15:0], mon_exp[16]);
          end
        end
      end
      mon_stall = (result_tvalid === 1'b1) && (result_tready === 1'b0);
      mon_data  = result_tdata;
      mon_user  = result_tuser;
    end else begin
      mon_stall = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------

  // Present x and keep it until accepted; leaves a_tvalid high for streaming.
  task automatic send(input longint x, input logic [16:0] exp);
    bit done;
    done     = 1'b0;
    a_tvalid = 1'b1;
    a_tdata  = 64'(x);
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (a_tready === 1'b1) begin
        exp_q.push_back(exp);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL send_timeout: a_tready stayed low for x=%0d, required acceptance", x);
    end
  endtask

  task automatic idle();
    a_tvalid = 1'b0;
    a_tdata  = 64'hDEAD_BEEF_0BAD_F00D;
  endtask

  // Wait until every accepted sample has been delivered.
  task automatic wait_drain(input string name);
    for (int n = 0; n < 300 && exp_q.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d samples outstanding, required 0", name, exp_q.size());
    end
  endtask

  // Single sample into an idle pipeline; checks it appears exactly 3 edges
  // after the accepting edge.
  task automatic measure_latency(input longint x, input logic [15:0] exp_data,
                                 input logic exp_user);
    int n;
    a_tvalid = 1'b1;
    a_tdata  = 64'(x);
    @(negedge clk);
    n_checks++;
    if (a_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_x%0d: a_tready=%b required 1", x, a_tready);
    end
    exp_q.push_back({exp_user, exp_data});
    @(posedge clk);
    #1;
    idle();
    n = 0;
    while (n < 10 && result_tvalid !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_checks++;
    if (n != 3) begin
      n_fail++;
      $display("FAIL latency_x%0d: output after %0d edges, required 3", x, n);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst           = 1'b1;
    result_tready = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (result_tvalid !== 1'b0 || result_tdata !== 16'd0 || result_tuser !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b data=%0d user=%b, required 0/0/0",
               result_tvalid, result_tdata, result_tuser);
    end
    n_checks++;
    if (err_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_err_count: got %0d required 0", err_count);
    end
    n_checks++;
    if (a_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_a_tready: got %b required 1", a_tready);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    result_tready = 1'b1;
    measure_latency(64'sd12289, 16'd0, 1'b0);
    measure_latency(-64'sd1, 16'd12288, 1'b0);
    measure_latency(64'sd0, 16'd0, 1'b0);
    wait_drain("basic");
  endtask

  task automatic test_limits();
    result_tready = 1'b1;
    send(64'sd2147483647, {1'b0, 16'd5475});
    send(-64'sd2147483648, {1'b0, 16'd6813});
    send(64'sd2147483648, {1'b1, 16'd0});
    idle();
    wait_drain("limits");
    n_checks++;
    if (err_count !== 16'd1) begin
      n_fail++;
      $display("FAIL limits_err_count: got %0d required 1", err_count);
    end
  endtask

  task automatic test_backpressure();
    bit done;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          int     v;
          longint x;
          v = $urandom;
          x = longint'(v);
          send(x, model(x));
        end
        idle();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          result_tready = 1'($urandom_range(0, 1));
        end
      end
    join
    result_tready = 1'b1;
    wait_drain("backpressure");
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (result_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_dup: result_tvalid=%b after drain, required 0", result_tvalid);
    end
  endtask

  task automatic test_reset_midstream();
    result_tready = 1'b1;
    send(64'sd5, model(64'sd5));
    send(64'sd6, model(64'sd6));
    send(64'sd7, model(64'sd7));
    idle();
    rst = 1'b1;
    exp_q.delete();
    #1;
    n_checks++;
    if (result_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_valid: got %b required 0", result_tvalid);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (result_tvalid !== 1'b0 || a_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_hold: valid=%b a_tready=%b, required 0/1", result_tvalid, a_tready);
    end
    rst = 1'b0;
    measure_latency(64'sd24578, 16'd0, 1'b0);
    wait_drain("midreset");
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (result_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_stale: result_tvalid=%b after drain, required 0", result_tvalid);
    end
  endtask

  task automatic test_err_counter();
    // Fresh counter
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // One error sample held for 5 cycles must count once.
    result_tready = 1'b0;
    measure_latency(64'sd2147483648, 16'd0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (err_count !== 16'd0 || result_tvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL err_hold: err_count=%0d valid=%b, required 0/1", err_count, result_tvalid);
    end
    result_tready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (err_count !== 16'd1) begin
      n_fail++;
      $display("FAIL err_release: err_count=%0d required 1", err_count);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (err_count !== 16'd1) begin
      n_fail++;
      $display("FAIL err_once: err_count=%0d required 1", err_count);
    end

    // Bring the counter to exactly 65535.
    for (int i = 0; i < 65534; i++) begin
      if (i % 2 == 0) send(64'sd2147483648 + longint'(i), {1'b1, 16'd0});
      else            send(-64'sd2147483649 - longint'(i), {1'b1, 16'd0});
    end
    idle();
    wait_drain("err_fill");
    n_checks++;
    if (err_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL err_full: err_count=%0d required 65535", err_count);
    end

    // Two more must not wrap.
    send(64'sh4000_0000_0000_0000, {1'b1, 16'd0});
    send(-64'sd4294967296, {1'b1, 16'd0});
    idle();
    wait_drain("err_sat");
    n_checks++;
    if (err_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL err_saturate: err_count=%0d required 65535", err_count);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_limits();
    test_backpressure();
    test_reset_midstream();
    test_err_counter();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
